// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit between execute and the data memory bus.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses without a bus access.
//
// state | meaning
// IDLE  | ready for a new op from the EXU
// REQ   | bus request presented, waiting for bus_req_ready
// RESP  | request accepted, waiting for bus_resp_valid
// DONE  | result presented to write-back, waiting for out_ready
module load_store_unit #(
  parameter int AW          = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_wen,
  input  logic [2:0]    in_func3,
  input  logic [AW-1:0] in_addr,
  input  logic [31:0]   in_wdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_rdata,
  output logic          out_err,
  output logic          bus_req_valid,
  input  logic          bus_req_ready,
  output logic          bus_wen,
  output logic [AW-1:0] bus_addr,
  output logic [31:0]   bus_wdata,
  output logic [3:0]    bus_wstrb,
  input  logic          bus_resp_valid,
  input  logic [31:0]   bus_rdata,
  input  logic          bus_resp_err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          wen_q;
  logic [2:0]    func3_q;
  logic [1:0]    off_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    strb_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic          illegal, misalign, fault, timeout;
  logic [31:0]   wshape;
  logic [3:0]    sshape;
  logic [31:0]   lane, load_val;

  assign illegal = in_wen ? (in_func3 >= 3'd3)
                          : (in_func3 == 3'b011 || in_func3[2:1] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = (in_func3[1:0] == 2'b01 && in_addr[0]) ||
                    (in_func3[1:0] == 2'b10 && in_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif
  assign fault   = illegal || misalign;
  // Counter reaches TIMEOUT_CYC on the coming edge
  assign timeout = (cnt >= TC_LAST);

  always_comb begin
    wshape = '0;
    sshape = '0;
    if (in_wen) begin
      case (in_func3[1:0])
        2'b00: begin
          wshape = {4{in_wdata[7:0]}};
          sshape = 4'b0001 << in_addr[1:0];
        end
        2'b01: begin
          wshape = {2{in_wdata[15:0]}};
          sshape = 4'b0011 << in_addr[1:0];
        end
        default: begin
          wshape = in_wdata;
          sshape = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    lane     = bus_rdata >> {off_q, 3'b000};
    load_val = lane;
    case (func3_q)
      3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_val = {24'b0, lane[7:0]};
      3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_val = {16'b0, lane[15:0]};
      default: load_val = lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A response arriving in the timeout cycle is taken, not discarded
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = fault ? DONE : REQ;
      REQ: begin
        if (bus_req_ready) state_nxt = RESP;
        else if (timeout)  state_nxt = DONE;
      end
      RESP:    if (bus_resp_valid || timeout) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      wen_q   <= 1'b0;
      func3_q <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt     <= '0;
            wen_q   <= in_wen;
            func3_q <= in_func3;
            off_q   <= in_addr[1:0];
            addr_q  <= {in_addr[AW-1:2], 2'b00};
            wdata_q <= wshape;
            strb_q  <= sshape;
            rdata_q <= '0;
            err_q   <= fault;
          end
        end
        REQ: begin
          cnt <= cnt + CW'(1);
          if (!bus_req_ready && timeout) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        RESP: begin
          cnt <= cnt + CW'(1);
          if (bus_resp_valid) begin
            err_q   <= bus_resp_err;
            rdata_q <= (bus_resp_err || wen_q) ? 32'd0 : load_val;
          end else if (timeout) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready      = (state == IDLE) && !rst;
  assign out_valid     = (state == DONE);
  assign out_rdata     = rdata_q;
  assign out_err       = err_q;
  assign bus_req_valid = (state == REQ);
  assign bus_wen       = wen_q;
  assign bus_addr      = addr_q;
  assign bus_wdata     = wdata_q;
  assign bus_wstrb     = strb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: the bench plays the bus, expected results go through a queue.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_wen;
  logic [2:0]  in_func3;
  logic [31:0] in_addr, in_wdata;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_rdata;
  logic        bus_req_valid, bus_req_ready, bus_wen;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_resp_valid, bus_resp_err;
  logic [31:0] bus_rdata;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } sb_t;
  sb_t sb[$];

  load_store_unit #(.AW(32), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
    .in_func3(in_func3), .in_addr(in_addr), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_wen(bus_wen),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_resp_valid(bus_resp_valid), .bus_rdata(bus_rdata), .bus_resp_err(bus_resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // rdy_dly: REQ cycles before bus_req_ready; resp_dly: cycles after handshake before response (<0 = never)
  task automatic run_op(input string tag, input logic wen, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int rdy_dly, input int resp_dly,
                        input logic [31:0] rd, input logic rerr,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                        input logic exp_bus, input logic [31:0] exp_bwd, input logic [3:0] exp_strb,
                        input int hold);
    sb_t e;
    int  req_wait = 0;
    int  resp_cnt = 0;
    bit  hs = 0;
    bit  bus_seen = 0;
    int  cyc;
    check1({tag, ":in_ready"}, in_ready, 1'b1);
    sb.push_back('{exp_rd, exp_err});
    in_valid = 1'b1; in_wen = wen; in_func3 = f3; in_addr = addr; in_wdata = wd;
    step();
    in_valid = 1'b0;
    for (cyc = 1; cyc < 40; cyc++) begin
      bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_err = 1'b0; bus_rdata = '0;
      if (out_valid) break;
      if (hs && resp_dly >= 0) begin
        if (resp_cnt == resp_dly) begin
          bus_resp_valid = 1'b1; bus_rdata = rd; bus_resp_err = rerr;
        end
        resp_cnt++;
      end
      if (bus_req_valid) begin
        bus_seen = 1'b1;
        check({tag, ":bus_addr"}, bus_addr, addr & 32'hFFFF_FFFC);
        check({tag, ":bus_wdata"}, bus_wdata, exp_bwd);
        check({tag, ":bus_wstrb"}, {28'b0, bus_wstrb}, {28'b0, exp_strb});
        check1({tag, ":bus_wen"}, bus_wen, wen);
        if (req_wait == rdy_dly) begin
          bus_req_ready = 1'b1;
          hs = 1'b1;
        end
        req_wait++;
      end
      step();
    end
    check1({tag, ":out_valid_seen"}, out_valid, 1'b1);
    check({tag, ":latency"}, 32'(cyc), 32'(exp_lat));
    check1({tag, ":bus_access"}, bus_seen, exp_bus);
    check1({tag, ":req_dropped"}, bus_req_valid, 1'b0);
    e = sb.pop_front();
    for (int i = 0; i <= hold; i++) begin
      check1({tag, ":out_valid_hold"}, out_valid, 1'b1);
      check({tag, ":out_rdata"}, out_rdata, e.rd);
      check1({tag, ":out_err"}, out_err, e.err);
      if (i < hold) step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check1({tag, ":back_idle"}, in_ready, 1'b1);
    check1({tag, ":out_valid_clr"}, out_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_wen = 1'b0; in_func3 = '0; in_addr = '0; in_wdata = '0;
    out_ready = 1'b0;
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_rdata = '0; bus_resp_err = 1'b0;
    repeat (3) step();
    check1("rst:in_ready", in_ready, 1'b0);
    check1("rst:out_valid", out_valid, 1'b0);
    check1("rst:bus_req_valid", bus_req_valid, 1'b0);
    rst = 1'b0;
    #1;

    // tag wen f3 addr wdata rdy resp rdata rerr | exp_rd err lat bus bwd strb hold
    run_op("lw", 1'b0, 3'b010, 32'h8000_0004, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0,
           32'hDEAD_BEEF, 1'b0, 3, 1'b1, 32'h0, 4'b0000, 0);
    run_op("lb", 1'b0, 3'b000, 32'h8000_0003, 32'h0, 0, 0, 32'h8011_2233, 1'b0,
           32'hFFFF_FF80, 1'b0, 3, 1'b1, 32'h0, 4'b0000, 2);
    run_op("lbu", 1'b0, 3'b100, 32'h8000_0003, 32'h0, 0, 0, 32'h8011_2233, 1'b0,
           32'h0000_0080, 1'b0, 3, 1'b1, 32'h0, 4'b0000, 0);
    run_op("lhu", 1'b0, 3'b101, 32'h8000_0002, 32'h0, 0, 0, 32'h8011_2233, 1'b0,
           32'h0000_8011, 1'b0, 3, 1'b1, 32'h0, 4'b0000, 0);
    run_op("lh", 1'b0, 3'b001, 32'h8000_0002, 32'h0, 2, 1, 32'h8011_2233, 1'b0,
           32'hFFFF_8011, 1'b0, 6, 1'b1, 32'h0, 4'b0000, 1);
    run_op("sb_stall", 1'b1, 3'b000, 32'h8000_0001, 32'h0000_00A5, 5, 0, 32'h0, 1'b0,
           32'h0, 1'b0, 8, 1'b1, 32'hA5A5_A5A5, 4'b0010, 0);
    run_op("sh", 1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 0, 0, 32'hFFFF_FFFF, 1'b0,
           32'h0, 1'b0, 3, 1'b1, 32'hABCD_ABCD, 4'b1100, 0);
    run_op("sw_timeout", 1'b1, 3'b010, 32'h8000_0008, 32'h0102_0304, 0, -1, 32'h0, 1'b0,
           32'h0, 1'b1, 9, 1'b1, 32'h0102_0304, 4'b1111, 1);
    run_op("lw_noready", 1'b0, 3'b010, 32'h8000_0000, 32'h0, 1000, -1, 32'h0, 1'b0,
           32'h0, 1'b1, 9, 1'b1, 32'h0, 4'b0000, 0);
    run_op("lw_resp_at_tmo", 1'b0, 3'b010, 32'h8000_0010, 32'h0, 0, 6, 32'h0BAD_F00D, 1'b0,
           32'h0BAD_F00D, 1'b0, 9, 1'b1, 32'h0, 4'b0000, 0);
    run_op("lw_buserr", 1'b0, 3'b010, 32'h8000_0014, 32'h0, 0, 0, 32'hFFFF_FFFF, 1'b1,
           32'h0, 1'b1, 3, 1'b1, 32'h0, 4'b0000, 0);
    run_op("ld_f3_011", 1'b0, 3'b011, 32'h8000_0000, 32'h0, 0, 0, 32'h0, 1'b0,
           32'h0, 1'b1, 1, 1'b0, 32'h0, 4'b0000, 0);
    run_op("ld_f3_110", 1'b0, 3'b110, 32'h8000_0000, 32'h0, 0, 0, 32'h0, 1'b0,
           32'h0, 1'b1, 1, 1'b0, 32'h0, 4'b0000, 0);
    run_op("st_f3_011", 1'b1, 3'b011, 32'h8000_0000, 32'h5555_5555, 0, 0, 32'h0, 1'b0,
           32'h0, 1'b1, 1, 1'b0, 32'h0, 4'b0000, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    run_op("lw_misal", 1'b0, 3'b010, 32'h8000_0002, 32'h0, 0, 0, 32'h1122_3344, 1'b0,
           32'h0, 1'b1, 1, 1'b0, 32'h0, 4'b0000, 0);
    run_op("sh_o3", 1'b1, 3'b001, 32'h8000_0003, 32'h0000_BEEF, 0, 0, 32'h0, 1'b0,
           32'h0, 1'b1, 1, 1'b0, 32'h0, 4'b0000, 0);
`else
    run_op("lw_misal", 1'b0, 3'b010, 32'h8000_0002, 32'h0, 0, 0, 32'h1122_3344, 1'b0,
           32'h0000_1122, 1'b0, 3, 1'b1, 32'h0, 4'b0000, 0);
    run_op("sh_o3", 1'b1, 3'b001, 32'h8000_0003, 32'h0000_BEEF, 0, 0, 32'h0, 1'b0,
           32'h0, 1'b0, 3, 1'b1, 32'hBEEF_BEEF, 4'b1000, 0);
`endif

    // reset while waiting in RESP
    in_valid = 1'b1; in_wen = 1'b1; in_func3 = 3'b010; in_addr = 32'h8000_0020; in_wdata = 32'h1122_3344;
    step();
    in_valid = 1'b0;
    check1("rstmid:req", bus_req_valid, 1'b1);
    check("rstmid:strb_pre", {28'b0, bus_wstrb}, 32'hF);
    bus_req_ready = 1'b1;
    step();
    bus_req_ready = 1'b0;
    rst = 1'b1;
    step();
    check1("rstmid:in_ready", in_ready, 1'b0);
    check1("rstmid:out_valid", out_valid, 1'b0);
    check1("rstmid:req_valid", bus_req_valid, 1'b0);
    check1("rstmid:bus_wen", bus_wen, 1'b0);
    check("rstmid:bus_addr", bus_addr, 32'h0);
    check("rstmid:bus_wdata", bus_wdata, 32'h0);
    check("rstmid:bus_wstrb", {28'b0, bus_wstrb}, 32'h0);
    check("rstmid:out_rdata", out_rdata, 32'h0);
    check1("rstmid:out_err", out_err, 1'b0);
    rst = 1'b0;
    #1;
    check1("rstmid:in_ready_after", in_ready, 1'b1);
    bus_resp_valid = 1'b1; bus_rdata = 32'hCAFE_F00D;
    step();
    bus_resp_valid = 1'b0; bus_rdata = '0;
    check1("late_resp:out_valid", out_valid, 1'b0);
    check1("late_resp:in_ready", in_ready, 1'b1);
    run_op("lw_after_rst", 1'b0, 3'b010, 32'h8000_000C, 32'h0, 0, 0, 32'h1357_9BDF, 1'b0,
           32'h1357_9BDF, 1'b0, 3, 1'b1, 32'h0, 4'b0000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit placed between the execute stage and the data memory bus. It accepts one memory operation at a time from the EXU, which supplies the address, store data and RISC-V funct3. It drives a valid/ready request bus with byte strobes and waits for the response. It returns sign- or zero-extended load data, or a store acknowledge, to write-back through a valid/ready handshake. Together with a multi-cycle fetch, it replaces the combinational `Memory` path in the single-cycle core.

## Interface
Parameters:
- AW, 32, address width
- TIMEOUT_CYC, 255, maximum number of bus-wait cycles before the op is aborted with error; must be ≥1

Ports:
- clk  in  1  clock; one clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  EXU presents an operation
- in_ready  out  1  LSU can accept
- in_wen  in  1  1 = store, 0 = load
- in_func3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- in_addr  in  AW  byte address
- in_wdata  in  32  store data (rs2)
- out_valid  out  1  result available
- out_ready  in  1  write-back consumes result
- out_rdata  out  32  extended load data; 0 for stores and errors
- out_err  out  1  misaligned, illegal funct3, bus error or timeout
- bus_req_valid  out  1  bus request
- bus_req_ready  in  1  bus accepts request
- bus_wen  out  1  write request
- bus_addr  out  AW  word-aligned address (low 2 bits 0)
- bus_wdata  out  32  lane-replicated store data
- bus_wstrb  out  4  byte strobes; 0 for reads
- bus_resp_valid  in  1  read data / write ack
- bus_rdata  in  32  read word
- bus_resp_err  in  1  bus error, qualified by bus_resp_valid

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE: in_ready=1. On in_valid, capture wen, func3, addr and wdata.
  - Legal op with no misalignment fault: go to REQ.
  - Otherwise: go to DONE with err=1; no bus access.
- REQ: bus_req_valid=1. bus_addr, bus_wen, bus_wdata and bus_wstrb stay stable until bus_req_ready. Then go to RESP.
- RESP: wait for bus_resp_valid, then latch rdata and err, and go to DONE. bus_resp_valid is ignored in every other state.
- DONE: out_valid=1, with out_rdata and out_err held stable until out_ready. Then go to IDLE.
- Timeout: a counter clears on entry to REQ and increments each cycle in REQ or RESP. When it reaches TIMEOUT_CYC, go to DONE with err=1 and out_rdata=0, and drop bus_req_valid.
- Illegal funct3:
  - loads: 011, 110, 111
  - stores: any value ≥ 011
- Store shaping, with o = addr[1:0]:
  - SB: wdata={4{b}}, strb=4'b0001<<o
  - SH: wdata={2{h}}, strb=4'b0011<<o
  - SW: strb=4'b1111
- Load shaping: w = bus_rdata >> (8*o), then:
  - LB sign-extends w[7:0]; LBU zero-extends w[7:0]
  - LH sign-extends w[15:0]; LHU zero-extends w[15:0]
  - LW passes w
- Any bus error forces out_rdata=0.
- Reset, at any point including mid-transaction: state becomes IDLE, counter 0, and all outputs 0 (in_ready=0 while rst is high). An outstanding bus transaction is abandoned; the bus is reset by the same rst.

## Timing
- Cycle 0: in_valid&&in_ready handshake.
- Cycle 1: bus_req_valid=1.
- Best case is bus_req_ready in cycle 1 and bus_resp_valid in cycle 2. out_valid is then asserted in cycle 3, so minimum accept-to-result latency is 3 cycles.
- Fault ops with no bus access: out_valid in cycle 1.
- Next accept is possible the cycle after the out handshake. There is no back-to-back overlap: throughput ≤ 1 op per 4 cycles.
- All outputs are registered or decoded from state only; no combinational in→out paths.
- Simultaneous timeout and bus_resp_valid in the same cycle: the response wins.

## Configuration
- LSU_MISALIGN_TRAP_EN:
  - Defined: a halfword with addr[0]=1, or a word with addr[1:0]≠0, yields err=1 after 1 cycle with no bus access.
  - Undefined: misaligned addresses are not checked. The low bits are used only for lane selection, so a halfword at o=3 produces strb 4'b1000 (upper byte dropped); the bus access proceeds normally.

## Test plan
- LW addr 0x80000004, bus ready immediately, rdata 0xDEADBEEF next cycle: out_valid at cycle 3, out_rdata=0xDEADBEEF, err=0.
- LB addr 0x80000003, rdata 0x80112233: out_rdata=0xFFFFFF80. LBU at the same address: 0x00000080. LHU addr 0x80000002: 0x00008011.
- SB addr 0x80000001, wdata 0x000000A5: bus_wdata=0xA5A5A5A5, bus_wstrb=4'b0010, bus_wen=1. bus_req_ready held low 5 cycles: request fields stay stable throughout.
- SW with bus_resp_valid never asserted and TIMEOUT_CYC=8: out_err=1 exactly 8 cycles after REQ entry, bus_req_valid deasserted.
- With LSU_MISALIGN_TRAP_EN: LW addr 0x80000002 gives out_valid at cycle 1, err=1, bus_req_valid never asserted. Load func3=3'b011 gives the same response.
- rst asserted during RESP: next cycle all outputs 0. After rst drops, in_ready=1 and a new LW completes normally; a late bus_resp_valid in IDLE is ignored.
